mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the multi-cycle core's instruction-fetch requester (I side) and its load/store requester (D side).
- Runs one memory transaction at a time. Each transaction goes through a command / wait / acknowledge FSM.
- Conflicts are resolved round-robin. Contention cycles are counted for performance reporting alongside the core's instruction counter.

Parameters:
- AW, 12, address width of requester and memory address buses.
- RD_LAT, 1, memory read latency in cycles after the command cycle; legal range 1..7.
- CNT_W, 32, width of the conflict counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- I_REQ  in  1  instruction read request; held until I_GNT.
- I_ADDR  in  AW  instruction address; stable while I_REQ=1.
- I_GNT  out  1  one-cycle pulse in the I-side command cycle.
- I_ACK  out  1  one-cycle pulse; I_RDATA valid.
- I_RDATA  out  32  captured read data.
- D_REQ  in  1  data request; held until D_GNT.
- D_WE  in  1  1 = write, 0 = read.
- D_BE  in  4  byte enables.
- D_ADDR  in  AW  data address.
- D_WDATA  in  32  write data.
- D_GNT  out  1  one-cycle pulse in the D-side command cycle.
- D_ACK  out  1  one-cycle completion pulse; for reads, D_RDATA valid.
- D_RDATA  out  32  captured read data.
- MEM_CSN  out  1  memory chip select, active-low.
- MEM_WEN  out  1  memory write enable, active-low (1 = read).
- MEM_BE  out  4  memory byte enables.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  32  memory write data.
- MEM_RDATA  in  32  memory read data; valid RD_LAT cycles after command.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- CONFLICT_CNT  out  CNT_W  number of arbitration decisions taken with both requests high.

Behaviour:
- Reset (async, RSTn=0), applied immediately regardless of state:
  - FSM goes to IDLE; any in-flight read is discarded and never acknowledged.
  - Output values: MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0.
  - GNT/ACK outputs=0, RDATA outputs=0, BUSY=0, CONFLICT_CNT=0.
  - LAST=I, so the first conflict after reset goes to D.
- States: IDLE, CMD, WAIT, DONE.
- Arbitration point: the rising edge ending any IDLE or DONE cycle.
  - Sample I_REQ/D_REQ.
  - Winner: if only one request is high, that side. If both, the side not equal to LAST.
  - On a decision, latch winner, address, WE (forced 0 for I), BE (forced 4'b1111 for I) and WDATA; set LAST=winner; go to CMD.
  - With no request, go to / stay in IDLE.
- CMD (exactly 1 cycle):
  - MEM_CSN=0; MEM_WEN=~WE; MEM_BE, MEM_ADDR, MEM_WDATA from the latched values.
  - Winner's GNT=1.
  - Next state: writes go to DONE; reads go to WAIT with the latency counter loaded to RD_LAT.
- WAIT:
  - Counter decrements each cycle; lasts RD_LAT cycles.
  - At the edge ending the last WAIT cycle, capture MEM_RDATA into the winner's RDATA register, then go to DONE.
  - The other RDATA register is unchanged.
- DONE (1 cycle): winner's ACK=1; this is also an arbitration point.
- Outside CMD: MEM_CSN=1, MEM_WEN=1, MEM_BE=0; MEM_ADDR and MEM_WDATA hold their last value.
- Latency:
  - Read: GNT at cycle c+1 after the sampling edge at the end of cycle c; ACK at c+RD_LAT+2.
  - Write: ACK at c+2.
  - Back-to-back: next CMD directly follows DONE.
- Requester rule: REQ high in the DONE cycle is a new request. A requester must drop REQ after GNT unless it issues another transaction.
- CONFLICT_CNT: +1 on each decision with both REQs high; saturates at all-ones (no wrap).
- Input changes while not at an arbitration point are ignored; latched values are used.

Test Plan:
1. Reset: hold RSTn=0 with random inputs -> MEM_CSN=1, MEM_WEN=1, MEM_BE=0, all GNT/ACK=0, RDATA=0, BUSY=0, CONFLICT_CNT=0.
2. I read, RD_LAT=1: I_REQ=1, I_ADDR=0x010 sampled at edge 0; memory returns 0xDEADBEEF -> cycle 1: I_GNT=1, MEM_CSN=0, MEM_WEN=1, MEM_BE=4'b1111, MEM_ADDR=0x010; cycle 3: I_ACK=1, I_RDATA=0xDEADBEEF; D_RDATA unchanged.
3. D write: D_WE=1, D_BE=4'b0011, D_ADDR=0x020, D_WDATA=0x12345678 -> CMD cycle: MEM_CSN=0, MEM_WEN=0, MEM_BE=4'b0011, MEM_WDATA=0x12345678; next cycle D_ACK=1; no WAIT cycles.
4. Contention: both REQs held high for 4 transactions, each side dropping REQ only after its own GNT -> grant order D, I, D, I; CONFLICT_CNT counts each two-sided decision, then stops once only one side is left requesting.
5. Reset mid-read, RD_LAT=3: pull RSTn low during the second WAIT cycle, release 2 cycles later -> immediate IDLE, MEM_CSN=1, no I_ACK/D_ACK ever for that transaction, BUSY=0.
6. Saturation/back-to-back: CNT_W=4, 20 contended reads -> CONFLICT_CNT stops at 4'hF; each new CMD occurs in the cycle right after the previous DONE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between the instruction-fetch (I) and load/store (D) requesters.
// Latency: read ACK at decision+RD_LAT+2, write ACK at decision+2; a new CMD can follow DONE directly.
// Backpressure: a requester holds REQ until its GNT; the loser keeps waiting and wins the next conflict (round-robin).
//
// Ports:
//   CLK, RSTn                     clock, asynchronous active-low reset
//   I_REQ/I_ADDR -> I_GNT/I_ACK/I_RDATA                instruction read side
//   D_REQ/D_WE/D_BE/D_ADDR/D_WDATA -> D_GNT/D_ACK/D_RDATA  load/store side
//   MEM_CSN/MEM_WEN/MEM_BE/MEM_ADDR/MEM_WDATA, MEM_RDATA    memory port (active-low strobes)
//   BUSY                          FSM not idle
//   CONFLICT_CNT                  saturating count of decisions taken with both sides requesting
module mem_port_arbiter #(
    parameter int AW     = 12,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             I_REQ,
    input  logic [AW-1:0]    I_ADDR,
    output logic             I_GNT,
    output logic             I_ACK,
    output logic [31:0]      I_RDATA,
    input  logic             D_REQ,
    input  logic             D_WE,
    input  logic [3:0]       D_BE,
    input  logic [AW-1:0]    D_ADDR,
    input  logic [31:0]      D_WDATA,
    output logic             D_GNT,
    output logic             D_ACK,
    output logic [31:0]      D_RDATA,
    output logic             MEM_CSN,
    output logic             MEM_WEN,
    output logic [3:0]       MEM_BE,
    output logic [AW-1:0]    MEM_ADDR,
    output logic [31:0]      MEM_WDATA,
    input  logic [31:0]      MEM_RDATA,
    output logic             BUSY,
    output logic [CNT_W-1:0] CONFLICT_CNT
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [2:0]       LAT_INIT = 3'(RD_LAT);

    state_t     state;
    logic       win_d;      // 1: current transaction belongs to D side
    logic       we_q;       // current transaction is a write
    logic       last_d;     // side that won the previous decision (1 = D)
    logic [2:0] lat_cnt;    // remaining WAIT cycles, last one is 1
    logic       pick_d;

    // D wins when it is alone, or when both request and I won last time.
    assign pick_d = D_REQ && (!I_REQ || !last_d);
    assign BUSY   = (state != IDLE);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= IDLE;
            win_d        <= 1'b0;
            we_q         <= 1'b0;
            last_d       <= 1'b0;
            lat_cnt      <= '0;
            I_GNT        <= 1'b0;
            I_ACK        <= 1'b0;
            I_RDATA      <= '0;
            D_GNT        <= 1'b0;
            D_ACK        <= 1'b0;
            D_RDATA      <= '0;
            MEM_CSN      <= 1'b1;
            MEM_WEN      <= 1'b1;
            MEM_BE       <= '0;
            MEM_ADDR     <= '0;
            MEM_WDATA    <= '0;
            CONFLICT_CNT <= '0;
        end else begin
            // Strobes and pulses default inactive; address/wdata hold their last value.
            I_GNT   <= 1'b0;
            D_GNT   <= 1'b0;
            I_ACK   <= 1'b0;
            D_ACK   <= 1'b0;
            MEM_CSN <= 1'b1;
            MEM_WEN <= 1'b1;
            MEM_BE  <= '0;
            case (state)
                IDLE, DONE: begin
                    if (I_REQ || D_REQ) begin
                        state   <= CMD;
                        win_d   <= pick_d;
                        last_d  <= pick_d;
                        MEM_CSN <= 1'b0;
                        if (pick_d) begin
                            we_q      <= D_WE;
                            MEM_WEN   <= ~D_WE;
                            MEM_BE    <= D_BE;
                            MEM_ADDR  <= D_ADDR;
                            MEM_WDATA <= D_WDATA;
                            D_GNT     <= 1'b1;
                        end else begin
                            // Instruction fetch is always a full-word read; write data is left untouched.
                            we_q      <= 1'b0;
                            MEM_BE    <= 4'hF;
                            MEM_ADDR  <= I_ADDR;
                            I_GNT     <= 1'b1;
                        end
                        if (I_REQ && D_REQ && (CONFLICT_CNT != CNT_MAX))
                            CONFLICT_CNT <= CONFLICT_CNT + CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                CMD: begin
                    if (we_q) begin
                        state <= DONE;
                        I_ACK <= ~win_d;
                        D_ACK <= win_d;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_INIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        state <= DONE;
                        I_ACK <= ~win_d;
                        D_ACK <= win_d;
                        if (win_d) D_RDATA <= MEM_RDATA;
                        else       I_RDATA <= MEM_RDATA;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: randomized and directed stimulus for mem_port_arbiter against a transaction-level reference model.
// Latency: model predicts GNT/ACK cycles from decision time arithmetic (c+1, c+2, c+RD_LAT+2).
// Backpressure: requesters hold REQ until the model reports their grant, then drop or reissue.
module tb_mem_port_arbiter;

    localparam int AW      = 12;
    localparam int RD_LAT  = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK, RSTn;
    logic             I_REQ, I_GNT, I_ACK;
    logic [AW-1:0]    I_ADDR;
    logic [31:0]      I_RDATA;
    logic             D_REQ, D_WE, D_GNT, D_ACK;
    logic [3:0]       D_BE;
    logic [AW-1:0]    D_ADDR;
    logic [31:0]      D_WDATA, D_RDATA;
    logic             MEM_CSN, MEM_WEN;
    logic [3:0]       MEM_BE;
    logic [AW-1:0]    MEM_ADDR;
    logic [31:0]      MEM_WDATA, MEM_RDATA;
    logic             BUSY;
    logic [CNT_W-1:0] CONFLICT_CNT;

    mem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_ACK(D_ACK), .D_RDATA(D_RDATA),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY), .CONFLICT_CNT(CONFLICT_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk, n_pass, cyc;
    logic [31:0] env_mem [0:4095];
    logic [31:0] ref_mem [0:4095];

    // Reference model: one transaction record plus decision bookkeeping.
    bit          tv, t_d, t_we, last_d, gi, gd;
    int          t_dec, t_gnt, t_ack, exp_cnt, b2b;
    logic [3:0]  t_be;
    logic [AW-1:0] t_addr, exp_maddr;
    logic [31:0] t_wdata, t_rdata, exp_i_rd, exp_d_rd;
    bit          glog[$];

    // Requester state.
    bit i_pend, d_pend;
    int i_left, d_left;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    endtask

    // Memory responder: applies writes, returns read data exactly RD_LAT cycles after the command cycle.
    initial begin : responder
        bit rd_pend;
        int rd_cd;
        logic [31:0] rd_dat;
        rd_pend = 1'b0; rd_cd = 0; rd_dat = '0;
        MEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            if (MEM_CSN === 1'b0 && MEM_WEN === 1'b0)
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) env_mem[MEM_ADDR][8*b +: 8] = MEM_WDATA[8*b +: 8];
            if (MEM_CSN === 1'b0 && MEM_WEN === 1'b1) begin
                rd_pend = 1'b1; rd_cd = RD_LAT; rd_dat = env_mem[MEM_ADDR];
            end else if (rd_pend) begin
                rd_cd--;
            end
            if (rd_pend && rd_cd == 0) begin
                MEM_RDATA = rd_dat; rd_pend = 1'b0;
            end else begin
                MEM_RDATA = $urandom;
            end
        end
    end

    task automatic model_reset();
        tv = 0; last_d = 0; exp_cnt = 0; exp_i_rd = '0; exp_d_rd = '0; exp_maddr = '0;
        gi = 0; gd = 0;
    endtask

    task automatic check_outputs();
        bit cmd, ack;
        cmd = tv && (cyc == t_gnt);
        ack = tv && (cyc == t_ack);
        if (ack && !t_we) begin
            if (t_d) exp_d_rd = t_rdata;
            else     exp_i_rd = t_rdata;
        end
        chk("i_gnt",   32'(I_GNT),   32'(cmd && !t_d));
        chk("d_gnt",   32'(D_GNT),   32'(cmd && t_d));
        chk("i_ack",   32'(I_ACK),   32'(ack && !t_d));
        chk("d_ack",   32'(D_ACK),   32'(ack && t_d));
        chk("busy",    32'(BUSY),    32'(tv && cyc > t_dec && cyc <= t_ack));
        chk("mem_csn", 32'(MEM_CSN), 32'(!cmd));
        chk("mem_wen", 32'(MEM_WEN), 32'(cmd ? !t_we : 1'b1));
        chk("mem_be",  32'(MEM_BE),  32'(cmd ? t_be : 4'h0));
        chk("mem_addr", 32'(MEM_ADDR), 32'(exp_maddr));
        if (cmd && t_we) chk("mem_wdata", MEM_WDATA, t_wdata);
        chk("i_rdata", I_RDATA, exp_i_rd);
        chk("d_rdata", D_RDATA, exp_d_rd);
        chk("conflict_cnt", 32'(CONFLICT_CNT), 32'(exp_cnt));
    endtask

    // Decision at the edge ending the current cycle, from the inputs as driven now.
    task automatic model_eval();
        bit wd;
        if (!RSTn) begin
            model_reset();
        end else if (!tv || cyc >= t_ack) begin
            if (I_REQ || D_REQ) begin
                if (tv && cyc == t_ack) b2b++;
                wd = (I_REQ && D_REQ) ? !last_d : D_REQ;
                if (I_REQ && D_REQ && exp_cnt < CNT_MAX) exp_cnt++;
                last_d = wd; tv = 1; t_d = wd;
                t_dec = cyc; t_gnt = cyc + 1;
                if (wd) begin
                    t_we = D_WE; t_be = D_BE; t_addr = D_ADDR; t_wdata = D_WDATA; gd = 1;
                end else begin
                    t_we = 0; t_be = 4'hF; t_addr = I_ADDR; gi = 1;
                end
                t_ack = t_we ? cyc + 2 : cyc + RD_LAT + 2;
                exp_maddr = t_addr;
                if (t_we) begin
                    for (int b = 0; b < 4; b++)
                        if (t_be[b]) ref_mem[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
                end else begin
                    t_rdata = ref_mem[t_addr];
                end
                glog.push_back(wd);
            end
        end
    endtask

    task automatic cycle_start();
        @(negedge CLK);
        cyc++;
        check_outputs();
    endtask

    task automatic idle_inputs();
        I_REQ = 0; D_REQ = 0; D_WE = 0; D_BE = '0;
        I_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
    endtask

    task automatic do_reset();
        cycle_start(); RSTn = 0; idle_inputs(); model_eval();
        cycle_start(); RSTn = 1; model_eval();
        i_pend = 0; d_pend = 0; glog.delete(); b2b = 0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic drive_reqs(input int prob, input bit rd_only);
        if (gi) begin i_pend = 0; gi = 0; end
        if (gd) begin d_pend = 0; gd = 0; end
        if (!i_pend && i_left > 0 && $urandom_range(0, 99) < prob) begin
            i_pend = 1; i_left--; I_ADDR = rand_addr();
        end else if (!i_pend) begin
            I_ADDR = AW'($urandom);
        end
        if (!d_pend && d_left > 0 && $urandom_range(0, 99) < prob) begin
            d_pend = 1; d_left--;
            D_WE = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
            D_BE = 4'($urandom); D_ADDR = rand_addr(); D_WDATA = $urandom;
        end else if (!d_pend) begin
            D_WE = 1'($urandom); D_BE = 4'($urandom); D_ADDR = AW'($urandom); D_WDATA = $urandom;
        end
        I_REQ = i_pend;
        D_REQ = d_pend;
    endtask

    task automatic i_read(input logic [AW-1:0] a);
        cycle_start(); I_REQ = 1; I_ADDR = a; model_eval();
        for (int k = 0; k < RD_LAT + 2; k++) begin
            cycle_start(); I_REQ = 0; I_ADDR = AW'($urandom); model_eval();
        end
    endtask

    initial begin : main
        int ack_seen;
        n_chk = 0; n_pass = 0; cyc = 0; b2b = 0;
        for (int a = 0; a < 4096; a++) begin env_mem[a] = '0; ref_mem[a] = '0; end
        env_mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
        i_pend = 0; d_pend = 0; i_left = 0; d_left = 0;
        model_reset();
        RSTn = 0; idle_inputs();

        // Reset held with random inputs.
        for (int k = 0; k < 5; k++) begin
            cycle_start();
            I_REQ = 1'($urandom); D_REQ = 1'($urandom); D_WE = 1'($urandom);
            D_BE = 4'($urandom); I_ADDR = AW'($urandom); D_ADDR = AW'($urandom); D_WDATA = $urandom;
            model_eval();
        end
        do_reset();

        // Single I read.
        i_read(12'h010);
        chk("t2_i_rdata", I_RDATA, 32'hDEADBEEF);
        chk("t2_d_rdata", D_RDATA, 32'h0);

        // Single D write, then read it back through the I side.
        cycle_start(); D_REQ = 1; D_WE = 1; D_BE = 4'b0011; D_ADDR = 12'h020; D_WDATA = 32'h12345678; model_eval();
        cycle_start(); D_REQ = 0; model_eval();
        chk("t3_wdata", MEM_WDATA, 32'h12345678);
        cycle_start(); model_eval();
        chk("t3_d_ack", 32'(D_ACK), 32'h1);
        i_read(12'h020);
        chk("t3_readback", I_RDATA, 32'h00005678);

        // Contention: two transactions per side, both requesting from the start.
        do_reset();
        i_left = 2; d_left = 2;
        for (int k = 0; k < 30; k++) begin cycle_start(); drive_reqs(100, 0); model_eval(); end
        chk("t4_grants", 32'(glog.size()), 32'd4);
        if (glog.size() == 4)
            chk("t4_order", 32'({glog[0], glog[1], glog[2], glog[3]}), 32'b1010);
        chk("t4_conflicts", 32'(CONFLICT_CNT), 32'd3);

        // Saturation and back-to-back contended reads.
        do_reset();
        i_left = 11; d_left = 11;
        for (int k = 0; k < 130; k++) begin cycle_start(); drive_reqs(100, 1); model_eval(); end
        chk("t6_cnt_sat", 32'(CONFLICT_CNT), 32'hF);
        chk("t6_grants", 32'(glog.size()), 32'd22);
        chk("t6_b2b", 32'(b2b), 32'd21);

        // Randomized traffic.
        do_reset();
        i_left = 1000000; d_left = 1000000;
        for (int k = 0; k < 1500; k++) begin cycle_start(); drive_reqs(35, 0); model_eval(); end
        i_left = 0; d_left = 0;
        for (int k = 0; k < 10; k++) begin cycle_start(); drive_reqs(0, 0); model_eval(); end

        // Reset during the second WAIT cycle of a read.
        do_reset();
        cycle_start(); I_REQ = 1; I_ADDR = 12'h010; model_eval();
        cycle_start(); I_REQ = 0; model_eval();
        cycle_start(); model_eval();
        cycle_start();
        chk("t5_busy_before", 32'(BUSY), 32'h1);
        RSTn = 0;
        #1;
        chk("t5_csn", 32'(MEM_CSN), 32'h1);
        chk("t5_busy", 32'(BUSY), 32'h0);
        model_eval();
        ack_seen = 0;
        cycle_start(); ack_seen += int'(I_ACK | D_ACK); model_eval();
        cycle_start(); ack_seen += int'(I_ACK | D_ACK); RSTn = 1; model_eval();
        for (int k = 0; k < 8; k++) begin
            cycle_start(); ack_seen += int'(I_ACK | D_ACK); model_eval();
        end
        chk("t5_no_ack", 32'(ack_seen), 32'h0);
        chk("t5_i_rdata", I_RDATA, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
